filtered_edge_detect: RTL and testbench



---
 rtl/filtered_edge_detect.sv | 94 +++++++++
 tb/tb_filtered_edge_detect.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filtered_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, mode-qualified
// one-cycle edge pulse, sticky edge flag and wrapping edge counter.
module filtered_edge_detect #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       d_in,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH-1:0]       d_level,
  output logic [NUM_CH-1:0]       d_edge,
  output logic [NUM_CH-1:0]       edge_flag,
  output logic [NUM_CH*CNT_W-1:0] edge_count
);

  localparam int unsigned FltW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FltW-1:0] FltMax = FltW'(FILTER_LEN - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [FltW-1:0]        flt_q, flt_d;
    logic                   level_q, level_d;
    logic                   accept;
    logic                   qual;
    logic                   pend_q;
    logic                   edge_q;
    logic                   flag_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             ch_mode;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign ch_mode = mode[2*i +: 2];

    always_comb begin
      flt_d   = flt_q;
      level_d = level_q;
      accept  = 1'b0;
      if (sync == level_q) begin
        flt_d = '0;
      end else if (flt_q == FltMax) begin
        flt_d   = '0;
        level_d = sync;
        accept  = 1'b1;
      end else begin
        flt_d = flt_q + FltW'(1);
      end
    end

    // On acceptance the new level equals sync, so sync=1 marks a rise.
    // Mode is captured here, at the flip, so later mode changes cannot retro-qualify.
    always_comb begin
      case (ch_mode)
        2'b01:   qual = accept & sync;
        2'b10:   qual = accept & ~sync;
        2'b11:   qual = accept;
        default: qual = 1'b0;
      endcase
    end

    // A clear coinciding with an edge still counts that edge.
    assign cnt_d = clear[i] ? CNT_W'(pend_q) : cnt_q + CNT_W'(pend_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q  <= '1;
        flt_q   <= '0;
        level_q <= 1'b1;
        pend_q  <= 1'b0;
        edge_q  <= 1'b0;
        flag_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], d_in[i]};
        flt_q   <= flt_d;
        level_q <= level_d;
        pend_q  <= qual;
        edge_q  <= pend_q;
        flag_q  <= pend_q | (flag_q & ~clear[i]);
        cnt_q   <= cnt_d;
      end
    end

    assign d_level[i]                 = level_q;
    assign d_edge[i]                  = edge_q;
    assign edge_flag[i]               = flag_q;
    assign edge_count[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_filtered_edge_detect.sv
// Scoreboard bench: stimulus pushes expected pulses (cycle, count); monitors pop on d_edge.
module tb_filtered_edge_detect;

  localparam int N = 4;

  typedef struct {
    int cyc;
    int cnt;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   d_in, clear, d_level, d_edge, edge_flag;
  logic [2*N-1:0] mode;
  logic [N*8-1:0] edge_count;

  logic [N-1:0]   b_d_in, b_clear, b_level, b_edge, b_flag;
  logic [2*N-1:0] b_mode;
  logic [N*2-1:0] b_count;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   cnt_a [N];
  ev_t  exp_a [N][$];
  ev_t  exp_b [N][$];
  ev_t  mon_ev, mon_evb;

  filtered_edge_detect dut_a (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .mode      (mode),
    .clear     (clear),
    .d_level   (d_level),
    .d_edge    (d_edge),
    .edge_flag (edge_flag),
    .edge_count(edge_count)
  );

  filtered_edge_detect #(.CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .d_in      (b_d_in),
    .mode      (b_mode),
    .clear     (b_clear),
    .d_level   (b_level),
    .d_edge    (b_edge),
    .edge_flag (b_flag),
    .edge_count(b_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_a(input int ch);
    ev_t e;
    cnt_a[ch] = (cnt_a[ch] + 1) % 256;
    e.cyc = cyc + 6;
    e.cnt = cnt_a[ch];
    exp_a[ch].push_back(e);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (exp_a[i].size() != 0 || exp_b[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while (n < 20 && !all_empty()) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < N; i++) begin
      if (exp_a[i].size() != 0 || exp_b[i].size() != 0) begin
        checks++;
        fails++;
        $display("FAIL missing_pulse ch%0d: got no pulse, expected %0d/%0d pending", i,
                 exp_a[i].size(), exp_b[i].size());
        exp_a[i].delete();
        exp_b[i].delete();
      end
    end
  endtask

  // Monitor for the CNT_W=8 instance.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (d_edge[i] !== 1'b0) begin
        if (exp_a[i].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL a_unexpected_pulse ch%0d: got pulse at cycle %0d, expected none", i, cyc);
        end else begin
          mon_ev = exp_a[i].pop_front();
          chk($sformatf("a_pulse_cycle ch%0d", i), cyc, mon_ev.cyc);
          chk($sformatf("a_pulse_count ch%0d", i), edge_count[i*8 +: 8], mon_ev.cnt);
          chk($sformatf("a_pulse_flag ch%0d", i), edge_flag[i], 1);
        end
      end
    end
  end

  // Monitor for the CNT_W=2 instance.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (b_edge[i] !== 1'b0) begin
        if (exp_b[i].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL b_unexpected_pulse ch%0d: got pulse at cycle %0d, expected none", i, cyc);
        end else begin
          mon_evb = exp_b[i].pop_front();
          chk($sformatf("b_pulse_cycle ch%0d", i), cyc, mon_evb.cyc);
          chk($sformatf("b_pulse_count ch%0d", i), b_count[i*2 +: 2], mon_evb.cnt);
        end
      end
    end
  end

  initial begin
    int   wrap_seq [5];
    ev_t  e;
    logic v;
    wrap_seq = '{1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) cnt_a[i] = 0;
    rst     = 1'b1;
    d_in    = '1;
    mode    = '0;
    clear   = '0;
    b_d_in  = '1;
    b_mode  = '0;
    b_clear = '0;
    repeat (2) @(negedge clk);
    chk("reset_level", d_level, 4'hf);
    chk("reset_edge", d_edge, 0);
    chk("reset_flag", edge_flag, 0);
    chk("reset_count", edge_count, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Rising-only channel 0: fall is ignored, rise pulses 6 cycles later.
    mode[1:0] = 2'b01;
    d_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    d_in[0] = 1'b1;
    expect_a(0);
    repeat (10) @(negedge clk);
    d_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    drain();
    chk("t1_count ch0", edge_count[7:0], 1);
    chk("t1_level ch0", d_level[0], 0);

    // Glitch rejection on channel 1 (both edges).
    mode[3:2] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      d_in[1] = 1'b0;
      repeat (2) @(negedge clk);
      d_in[1] = 1'b1;
      repeat (8) @(negedge clk);
    end
    chk("t2_glitch_level ch1", d_level[1], 1);
    chk("t2_glitch_count ch1", edge_count[15:8], 0);
    d_in[1] = 1'b0;
    expect_a(1);
    repeat (3) @(negedge clk);
    d_in[1] = 1'b1;
    expect_a(1);
    repeat (10) @(negedge clk);
    drain();
    chk("t2_count ch1", edge_count[15:8], 2);

    // Counter wrap on the CNT_W=2 instance, channel 2.
    b_mode[5:4] = 2'b11;
    for (int k = 0; k < 5; k++) begin
      b_d_in[2] = ~b_d_in[2];
      e.cyc = cyc + 6;
      e.cnt = wrap_seq[k];
      exp_b[2].push_back(e);
      repeat (8) @(negedge clk);
    end
    drain();
    chk("t4_final_count", b_count[5:4], 1);

    // Clear coinciding with a qualified edge on channel 3.
    mode[7:6] = 2'b11;
    d_in[3] = 1'b0;
    expect_a(3);
    repeat (10) @(negedge clk);
    drain();
    d_in[3] = 1'b1;
    cnt_a[3] = 0;
    expect_a(3);
    repeat (5) @(negedge clk);
    clear[3] = 1'b1;
    @(negedge clk);
    clear[3] = 1'b0;
    drain();
    chk("t5_flag_kept", edge_flag[3], 1);
    chk("t5_count_one", edge_count[31:24], 1);
    repeat (3) @(negedge clk);
    clear[3] = 1'b1;
    @(negedge clk);
    clear[3] = 1'b0;
    cnt_a[3] = 0;
    chk("t5_flag_cleared", edge_flag[3], 0);
    chk("t5_count_cleared", edge_count[31:24], 0);

    // Same square wave on all channels, modes 00/01/10/11.
    mode = '0;
    d_in = '0;
    repeat (10) @(negedge clk);
    mode = {2'b11, 2'b10, 2'b01, 2'b00};
    v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = ~v;
      d_in = {N{v}};
      if (v) expect_a(1);
      else   expect_a(2);
      expect_a(3);
      repeat (6) @(negedge clk);
      chk("t6_level_tracks ch0", d_level[0], v);
      repeat (4) @(negedge clk);
    end
    drain();
    chk("t6_off_count ch0", edge_count[7:0], 1);

    // Mode swap after the flip: the pending rise keeps its mode, next fall uses the new one.
    d_in = '1;
    expect_a(1);
    expect_a(3);
    repeat (5) @(negedge clk);
    mode[3:2] = 2'b10;
    mode[5:4] = 2'b01;
    repeat (5) @(negedge clk);
    d_in = '0;
    expect_a(1);
    expect_a(3);
    repeat (10) @(negedge clk);
    drain();

    // Reset mid-filter, then release with lines low and falling mode everywhere.
    mode   = '0;
    b_mode = '0;
    d_in   = '1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t3_rst_level", d_level, 4'hf);
    chk("t3_rst_edge", d_edge, 0);
    chk("t3_rst_flag", edge_flag, 0);
    chk("t3_rst_count", edge_count, 0);
    for (int i = 0; i < N; i++) cnt_a[i] = 0;
    mode = {N{2'b10}};
    d_in = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) expect_a(i);
    repeat (10) @(negedge clk);
    drain();
    chk("t3_flags_all", edge_flag, 4'hf);
    chk("t3_counts_all", edge_count, 32'h01010101);

    repeat (5) @(negedge clk);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
